upstream_loop_unit: RTL and testbench
=====================================

Name: upstream_loop_unit

Overview:
- Parametrised multi-channel user-side traffic engine for the Aurora 64b66b wrapper, in the wrapper's user_clk domain.
- Per channel, selectable modes:
  - idle;
  - buffered RX->TX loopback with proper tx_tready backpressure handling;
  - test-pattern generator with RX sequence checker.
- Replaces the hard-wired, unbuffered single-channel RX->TX loopback.
- Exports per-channel drop/error statistics.

Parameters:
- CH_CNT, 2, number of Aurora channels (>=1).
- DW, 128, AXIS data width in bits; multiple of 32.
- FIFO_DEPTH, 16, loopback FIFO depth in beats; power of 2, >=4.
- FRAME_LEN, 64, generator frame length in beats (>=1).

Ports:
- clk  in  1  user clock (Aurora user_clk).
- rst_n  in  1  synchronous reset, active-low.
- mode  in  [CH_CNT][1:0]  0=IDLE, 1=LOOP, 2=GEN, 3=reserved (treated as IDLE).
- channel_up  in  [CH_CNT]  Aurora channel status.
- clr_stat  in  [CH_CNT]  pulse: clear counters and overflow flag.
- rx_tdata  in  [CH_CNT][DW]  AXIS RX data (no backpressure).
- rx_tkeep  in  [CH_CNT][DW/8]  AXIS RX byte enables.
- rx_tvalid  in  [CH_CNT]  AXIS RX valid.
- rx_tlast  in  [CH_CNT]  AXIS RX end of frame.
- tx_tdata  out  [CH_CNT][DW]  AXIS TX data.
- tx_tkeep  out  [CH_CNT][DW/8]  AXIS TX byte enables.
- tx_tvalid  out  [CH_CNT]  AXIS TX valid.
- tx_tlast  out  [CH_CNT]  AXIS TX end of frame.
- tx_tready  in  [CH_CNT]  AXIS TX ready.
- overflow  out  [CH_CNT]  sticky: loopback FIFO overflowed.
- drop_cnt  out  [CH_CNT][15:0]  dropped RX beats, saturating.
- err_cnt  out  [CH_CNT][15:0]  checker mismatches, saturating.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is synchronous, active-low.
  - While rst_n=0, all outputs are 0 on the next edge: tx_* = 0, overflow = 0, counters = 0, FIFO empty, active mode = IDLE.
- Channel independence:
  - Channels are fully independent; all rules below apply per channel.
- Active mode:
  - The active mode register loads from mode only at a TX frame boundary:
    - tx_tvalid=0, or
    - the cycle a tx_tlast beat is accepted (tx_tvalid & tx_tready).
  - On a mode change, the FIFO is flushed, the generator seq is reset to 0, and the checker is resynced, all in the same cycle.
- Link down:
  - channel_up=0 forces immediately: FIFO flush, tx_tvalid=0, generator and checker reset, drop state cleared.
  - Active mode still tracks mode.
  - Counters hold their values.
- IDLE:
  - tx_tvalid=0.
  - RX beats are ignored and not counted.
- LOOP:
  - Show-ahead FIFO, FIFO_DEPTH x (DW + DW/8 + 1) bits.
  - An RX beat written at edge N is presented on tx_* after edge N (latency 1).
  - tx_* holds stable while tx_tvalid & !tx_tready.
  - Simultaneous read and write when full is allowed: the read frees the slot, so no overflow.
  - Overflow: an rx_tvalid beat arriving when full and not reading:
    - that beat is dropped; overflow is set; drop_cnt increments;
    - the channel enters DROP and discards every further RX beat, each counted, up to and including the next rx_tlast;
    - it then returns to PASS, so TX never carries a truncated-and-spliced frame.
    - A beat with rx_tlast that itself overflows ends the frame: the next beat is PASS.
  - FSM: PASS -> DROP on overflow; DROP -> PASS on a consumed rx_tlast beat; link-down or mode change -> PASS.
- GEN:
  - Generator:
    - tx_tdata = DW/32 copies of a 32-bit seq; tx_tkeep = all ones.
    - tx_tlast is asserted on every FRAME_LEN-th beat.
    - seq and the beat counter advance only on an accepted beat; seq wraps 2^32-1 -> 0.
    - tx_tvalid = 1 continuously while channel_up.
  - Checker:
    - Each rx_tvalid beat's low 32 bits are compared with the expected value.
    - The first beat after resync is always accepted and sets expected = rx+1.
    - On a mismatch: err_cnt increments and expected = rx+1 (resync).
    - The checker does not examine tkeep or tlast.
- Counters:
  - 16-bit, saturate at 0xFFFF.
  - clr_stat has priority over a simultaneous increment: result is 0.
  - clr_stat also clears overflow.

Decomposition:
- Shared package upstream_pkg:
  - typedef enum logic [1:0] upstream_mode_e {UP_IDLE, UP_LOOP, UP_GEN, UP_RSVD};
  - typedef enum logic drop_state_e {ST_PASS, ST_DROP};
  - localparam SEQ_W = 32; localparam STAT_W = 16.
- Sub-module upstream_ch (one channel: FIFO, drop FSM, generator, checker, counters), instantiated CH_CNT times in a generate loop.
- The top level only slices the packed arrays.

Test Plan:
- LOOP, tx_tready=1, 10-beat frame rx data 0..9 -> tx beats 0..9 one cycle later, tlast on beat 9; drop_cnt=0, overflow=0.
- LOOP, FIFO_DEPTH=16, tx_tready=0, 20-beat frame -> 16 beats stored, beats 16..19 dropped (drop_cnt=4, overflow=1); next frame passes intact once tx_tready=1.
- LOOP with tx_tready toggling 1/0 every cycle, FIFO full and reading while writing -> no drop, tx order preserved, tx_* stable while stalled.
- GEN, FRAME_LEN=4, tx looped externally to rx, run 40 beats -> seq 0..39, tlast at beats 3,7,..., err_cnt=0; inject seq 100 in place of 20 -> err_cnt=1; following 101,102 clean.
- Mode LOOP->GEN mid-frame -> switch only after the current tx_tlast is accepted; FIFO flushed, GEN starts at seq 0.
- channel_up drop mid-frame -> tx_tvalid=0 next cycle, FIFO empty; err_cnt preserved; clr_stat with a simultaneous error -> err_cnt=0; rst_n=0 -> all outputs 0.

Source files
------------

// File: rtl/upstream_pkg.sv
// Shared types and widths for the upstream loop unit: channel modes, drop FSM states,
// sequence/statistics widths and a saturating counter helper.
package upstream_pkg;

    typedef enum logic [1:0] {
        UP_IDLE = 2'd0,
        UP_LOOP = 2'd1,
        UP_GEN  = 2'd2,
        UP_RSVD = 2'd3
    } upstream_mode_e;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } drop_state_e;

    localparam int unsigned SEQ_W  = 32;
    localparam int unsigned STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/upstream_ch.sv
// One Aurora channel: loopback FIFO with frame-drop FSM, sequence generator,
// sequence checker and saturating statistics.
module upstream_ch
    import upstream_pkg::*;
#(
    parameter int unsigned DW         = 128,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_LEN  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic              channel_up_i,
    input  logic              clr_stat_i,
    input  logic [DW-1:0]     rx_tdata_i,
    input  logic [DW/8-1:0]   rx_tkeep_i,
    input  logic              rx_tvalid_i,
    input  logic              rx_tlast_i,
    output logic [DW-1:0]     tx_tdata_o,
    output logic [DW/8-1:0]   tx_tkeep_o,
    output logic              tx_tvalid_o,
    output logic              tx_tlast_o,
    input  logic              tx_tready_i,
    output logic              overflow_o,
    output logic [STAT_W-1:0] drop_cnt_o,
    output logic [STAT_W-1:0] err_cnt_o
);
    localparam int unsigned KW   = DW / 8;
    localparam int unsigned EW   = DW + KW + 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned BW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned NREP = DW / SEQ_W;

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    upstream_mode_e    act_q, act_d, req_c;
    drop_state_e       drop_q, drop_d;
    logic              link_q;
    logic [SEQ_W-1:0]  seq_q, seq_d, exp_q, exp_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              sync_q, sync_d;
    logic              ovf_q, ovf_d;
    logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;
    logic [EW-1:0]     head_c;
    logic              vld_c, last_c, accept_c, boundary_c, flush_c;
    logic              wr_en_c, inc_drop_c, inc_err_c;

    // TX view: FIFO head in LOOP, sequence word in GEN, zero otherwise
    always_comb begin
        head_c      = mem_q[rd_ptr_q];
        vld_c       = ((act_q == UP_LOOP) && (count_q != '0)) || ((act_q == UP_GEN) && link_q);
        last_c      = 1'b0;
        tx_tdata_o  = '0;
        tx_tkeep_o  = '0;
        if (vld_c) begin
            if (act_q == UP_GEN) begin
                tx_tdata_o = {NREP{seq_q}};
                tx_tkeep_o = '1;
                last_c     = (beat_q == BW'(FRAME_LEN - 1));
            end else begin
                tx_tdata_o = head_c[EW-1 -: DW];
                tx_tkeep_o = head_c[KW:1];
                last_c     = head_c[0];
            end
        end
        tx_tvalid_o = vld_c;
        tx_tlast_o  = last_c;
    end

    always_comb begin
        act_d      = act_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        beat_d     = beat_q;
        sync_d     = sync_q;
        exp_d      = exp_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        wr_en_c    = 1'b0;
        inc_drop_c = 1'b0;
        inc_err_c  = 1'b0;
        req_c      = (mode_i == UP_RSVD) ? UP_IDLE : upstream_mode_e'(mode_i);
        accept_c   = vld_c & tx_tready_i;
        boundary_c = !vld_c || (accept_c && last_c);
        flush_c    = !channel_up_i || (boundary_c && (req_c != act_q));

        if (flush_c) begin
            act_d    = req_c;
            drop_d   = ST_PASS;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            seq_d    = '0;
            beat_d   = '0;
            sync_d   = 1'b0;
        end else begin
            case (act_q)
                UP_LOOP: begin
                    sync_d = 1'b0;
                    if (rx_tvalid_i) begin
                        if (drop_q == ST_DROP) begin
                            inc_drop_c = 1'b1;
                            if (rx_tlast_i) drop_d = ST_PASS;
                        end else if ((count_q == CW'(FIFO_DEPTH)) && !accept_c) begin
                            // a lone overflowing tlast beat closes the frame itself
                            inc_drop_c = 1'b1;
                            ovf_d      = 1'b1;
                            if (!rx_tlast_i) drop_d = ST_DROP;
                        end else begin
                            wr_en_c = 1'b1;
                        end
                    end
                    if (wr_en_c)  wr_ptr_d = wr_ptr_q + AW'(1);
                    if (accept_c) rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d = count_q + CW'(wr_en_c) - CW'(accept_c);
                end
                UP_GEN: begin
                    if (accept_c) begin
                        seq_d  = seq_q + SEQ_W'(1);
                        beat_d = last_c ? '0 : beat_q + BW'(1);
                    end
                    if (rx_tvalid_i) begin
                        inc_err_c = sync_q && (rx_tdata_i[SEQ_W-1:0] != exp_q);
                        sync_d    = 1'b1;
                        exp_d     = rx_tdata_i[SEQ_W-1:0] + SEQ_W'(1);
                    end
                end
                default: sync_d = 1'b0;
            endcase
        end

        if (clr_stat_i) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            if (inc_drop_c) drop_cnt_d = sat_inc(drop_cnt_q);
            if (inc_err_c)  err_cnt_d  = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q      <= UP_IDLE;
            drop_q     <= ST_PASS;
            link_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            beat_q     <= '0;
            sync_q     <= 1'b0;
            exp_q      <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            act_q      <= act_d;
            drop_q     <= drop_d;
            link_q     <= channel_up_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            beat_q     <= beat_d;
            sync_q     <= sync_d;
            exp_q      <= exp_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_ptr_q] <= {rx_tdata_i, rx_tkeep_i, rx_tlast_i};
    end

    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_cnt_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/upstream_loop_unit.sv
// Multi-channel user-side traffic engine for the Aurora 64b66b wrapper;
// slices the per-channel packed buses onto independent upstream_ch instances.
module upstream_loop_unit
    import upstream_pkg::*;
#(
    parameter int unsigned CH_CNT     = 2,
    parameter int unsigned DW         = 128,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_LEN  = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CH_CNT-1:0][1:0]        mode,
    input  logic [CH_CNT-1:0]             channel_up,
    input  logic [CH_CNT-1:0]             clr_stat,
    input  logic [CH_CNT-1:0][DW-1:0]     rx_tdata,
    input  logic [CH_CNT-1:0][DW/8-1:0]   rx_tkeep,
    input  logic [CH_CNT-1:0]             rx_tvalid,
    input  logic [CH_CNT-1:0]             rx_tlast,
    output logic [CH_CNT-1:0][DW-1:0]     tx_tdata,
    output logic [CH_CNT-1:0][DW/8-1:0]   tx_tkeep,
    output logic [CH_CNT-1:0]             tx_tvalid,
    output logic [CH_CNT-1:0]             tx_tlast,
    input  logic [CH_CNT-1:0]             tx_tready,
    output logic [CH_CNT-1:0]             overflow,
    output logic [CH_CNT-1:0][STAT_W-1:0] drop_cnt,
    output logic [CH_CNT-1:0][STAT_W-1:0] err_cnt
);

    for (genvar g = 0; g < CH_CNT; g++) begin : g_ch
        upstream_ch #(
            .DW         (DW),
            .FIFO_DEPTH (FIFO_DEPTH),
            .FRAME_LEN  (FRAME_LEN)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .mode_i       (mode[g]),
            .channel_up_i (channel_up[g]),
            .clr_stat_i   (clr_stat[g]),
            .rx_tdata_i   (rx_tdata[g]),
            .rx_tkeep_i   (rx_tkeep[g]),
            .rx_tvalid_i  (rx_tvalid[g]),
            .rx_tlast_i   (rx_tlast[g]),
            .tx_tdata_o   (tx_tdata[g]),
            .tx_tkeep_o   (tx_tkeep[g]),
            .tx_tvalid_o  (tx_tvalid[g]),
            .tx_tlast_o   (tx_tlast[g]),
            .tx_tready_i  (tx_tready[g]),
            .overflow_o   (overflow[g]),
            .drop_cnt_o   (drop_cnt[g]),
            .err_cnt_o    (err_cnt[g])
        );
    end

endmodule

// File: tb/tb_upstream_loop_unit.sv
// Directed bench for upstream_loop_unit: channel 0 walks LOOP/GEN/link/clear/reset
// scenarios, channel 1 runs GEN with its own stall and sequence pattern.
module tb_upstream_loop_unit;
    localparam int CH = 2;
    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int FDEPTH = 16;
    localparam int FLEN = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic clk, rst_n;
    logic [CH-1:0][1:0]    mode;
    logic [CH-1:0]         channel_up, clr_stat, rx_tvalid, rx_tlast, tx_tvalid, tx_tlast, tx_tready, overflow;
    logic [CH-1:0][DW-1:0] rx_tdata, tx_tdata;
    logic [CH-1:0][KW-1:0] rx_tkeep, tx_tkeep;
    logic [CH-1:0][15:0]   drop_cnt, err_cnt;

    upstream_loop_unit #(.CH_CNT(CH), .DW(DW), .FIFO_DEPTH(FDEPTH), .FRAME_LEN(FLEN)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .channel_up(channel_up), .clr_stat(clr_stat),
        .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
        .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
        .tx_tready(tx_tready), .overflow(overflow), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input int c, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s ch%0d @%0t: got %h want %h", nm, c, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    beat_t       m_fifo[CH][$];
    int          m_mode[CH];
    bit          m_drop[CH], m_link[CH], m_sync[CH], m_ovf[CH];
    logic [31:0] m_seq[CH], m_exp[CH];
    int          m_beat[CH], m_dcnt[CH], m_ecnt[CH];

    function automatic bit m_valid(input int c);
        if (m_mode[c] == 1) return m_fifo[c].size() != 0;
        if (m_mode[c] == 2) return m_link[c];
        return 1'b0;
    endfunction

    function automatic beat_t m_head(input int c);
        beat_t b;
        if (m_mode[c] == 2) begin
            b.d = {(DW/32){m_seq[c]}};
            b.k = '1;
            b.l = (m_beat[c] == FLEN - 1);
        end else begin
            b = m_fifo[c][0];
        end
        return b;
    endfunction

    task automatic model_step(input int c);
        bit v, l, acc, bnd, idrop, ierr, full;
        int req;
        logic [31:0] r;
        if (!rst_n) begin
            m_fifo[c].delete();
            m_mode[c] = 0; m_drop[c] = 0; m_link[c] = 0; m_sync[c] = 0; m_ovf[c] = 0;
            m_seq[c] = 0; m_exp[c] = 0; m_beat[c] = 0; m_dcnt[c] = 0; m_ecnt[c] = 0;
            return;
        end
        v = m_valid(c);
        l = v ? m_head(c).l : 1'b0;
        acc = v && tx_tready[c];
        bnd = !v || (acc && l);
        req = (mode[c] == 2'd3) ? 0 : int'(mode[c]);
        idrop = 0; ierr = 0;
        if (!channel_up[c] || (bnd && req != m_mode[c])) begin
            m_mode[c] = req;
            m_fifo[c].delete();
            m_drop[c] = 0; m_seq[c] = 0; m_beat[c] = 0; m_sync[c] = 0;
        end else if (m_mode[c] == 1) begin
            full = (m_fifo[c].size() == FDEPTH);
            if (acc) void'(m_fifo[c].pop_front());
            if (rx_tvalid[c]) begin
                if (m_drop[c]) begin
                    idrop = 1;
                    if (rx_tlast[c]) m_drop[c] = 0;
                end else if (full && !acc) begin
                    idrop = 1; m_ovf[c] = 1;
                    if (!rx_tlast[c]) m_drop[c] = 1;
                end else begin
                    m_fifo[c].push_back({rx_tdata[c], rx_tkeep[c], rx_tlast[c]});
                end
            end
            m_sync[c] = 0;
        end else if (m_mode[c] == 2) begin
            if (acc) begin
                m_seq[c] = m_seq[c] + 32'd1;
                m_beat[c] = (m_beat[c] + 1) % FLEN;
            end
            if (rx_tvalid[c]) begin
                r = rx_tdata[c][31:0];
                if (m_sync[c] && r != m_exp[c]) ierr = 1;
                m_sync[c] = 1;
                m_exp[c] = r + 32'd1;
            end
        end else begin
            m_sync[c] = 0;
        end
        m_link[c] = channel_up[c];
        if (clr_stat[c]) begin
            m_ovf[c] = 0; m_dcnt[c] = 0; m_ecnt[c] = 0;
        end else begin
            if (idrop && m_dcnt[c] < 65535) m_dcnt[c]++;
            if (ierr && m_ecnt[c] < 65535) m_ecnt[c]++;
        end
    endtask

    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) model_step(c);
    end

    // ---------------- per-cycle comparison ----------------
    bit            pv_ok[CH], pv_v[CH], pv_r[CH], pv_l[CH];
    logic [DW-1:0] pv_d[CH];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < CH; c++) begin
                bit    ev;
                beat_t eh;
                ev = m_valid(c);
                chk("tvalid", c, DW'(tx_tvalid[c]), DW'(ev));
                if (ev) begin
                    eh = m_head(c);
                    chk("tdata", c, tx_tdata[c], eh.d);
                    chk("tkeep", c, DW'(tx_tkeep[c]), DW'(eh.k));
                    chk("tlast", c, DW'(tx_tlast[c]), DW'(eh.l));
                end
                chk("overflow", c, DW'(overflow[c]), DW'(m_ovf[c]));
                chk("drop_cnt", c, DW'(drop_cnt[c]), DW'(m_dcnt[c]));
                chk("err_cnt", c, DW'(err_cnt[c]), DW'(m_ecnt[c]));
                if (pv_ok[c] && pv_v[c] && !pv_r[c]) begin
                    chk("stall_data", c, tx_tdata[c], pv_d[c]);
                    chk("stall_last", c, DW'(tx_tlast[c]), DW'(pv_l[c]));
                end
                pv_ok[c] = rst_n && channel_up[c];
                pv_v[c] = tx_tvalid[c];
                pv_r[c] = tx_tready[c];
                pv_l[c] = tx_tlast[c];
                pv_d[c] = tx_tdata[c];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tx_tready[1] = (cyc % 3) != 0;
        rx_tvalid[1] = 1'b1;
        rx_tdata[1]  = DW'(cyc + ((cyc >= 60) ? 7 : 0));
    endtask

    task automatic rx0(input logic v, input logic [DW-1:0] d, input logic l);
        rx_tvalid[0] = v;
        rx_tdata[0]  = d;
        rx_tlast[0]  = l;
        rx_tkeep[0]  = l ? 16'h00FF : 16'hFFFF;
    endtask

    initial begin
        rst_n = 0; mode = '0; channel_up = '1; clr_stat = '0;
        rx_tdata = '0; rx_tkeep = '0; rx_tvalid = '0; rx_tlast = '0; tx_tready = '0;
        mode[1] = 2'd2; rx_tkeep[1] = '1;
        step();
        chk_en = 1;
        step();
        for (int c = 0; c < CH; c++) begin
            chk("rst_tvalid", c, DW'(tx_tvalid[c]), '0);
            chk("rst_tdata", c, tx_tdata[c], '0);
        end
        rst_n = 1;

        // 1: LOOP pass-through, latency one
        mode[0] = 2'd1; tx_tready[0] = 1;
        step();
        for (int i = 0; i < 10; i++) begin
            rx0(1, DW'(i), i == 9);
            step();
            chk("t1_data", 0, DW'(tx_tdata[0][31:0]), DW'(i));
            chk("t1_last", 0, DW'(tx_tlast[0]), DW'(i == 9));
        end
        rx0(0, '0, 0);
        step();
        chk("t1_empty", 0, DW'(tx_tvalid[0]), '0);
        chk("t1_drop", 0, DW'(drop_cnt[0]), '0);

        // 2: overflow drops remainder of the frame
        tx_tready[0] = 0;
        for (int i = 0; i < 20; i++) begin
            rx0(1, DW'(100 + i), i == 19);
            step();
        end
        rx0(0, '0, 0);
        step();
        chk("t2_drop", 0, DW'(drop_cnt[0]), DW'(4));
        chk("t2_ovf", 0, DW'(overflow[0]), DW'(1));
        tx_tready[0] = 1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain", 0, DW'(tx_tdata[0][31:0]), DW'(100 + i));
            step();
        end
        for (int i = 0; i < 4; i++) begin
            rx0(1, DW'(200 + i), i == 3);
            step();
        end
        rx0(0, '0, 0);
        step();
        chk("t2_drop_hold", 0, DW'(drop_cnt[0]), DW'(4));

        // 3: full FIFO, read+write together under toggling ready
        clr_stat[0] = 1;
        step();
        clr_stat[0] = 0;
        chk("t3_clr_drop", 0, DW'(drop_cnt[0]), '0);
        chk("t3_clr_ovf", 0, DW'(overflow[0]), '0);
        tx_tready[0] = 0;
        for (int i = 0; i < 16; i++) begin
            rx0(1, DW'(400 + i), i == 15);
            step();
        end
        for (int j = 0; j < 12; j++) begin
            tx_tready[0] = (j % 2) == 0;
            rx0(tx_tready[0], DW'(500 + j / 2), j == 10);
            step();
        end
        rx0(0, '0, 0);
        chk("t3_head", 0, DW'(tx_tdata[0][31:0]), DW'(406));
        chk("t3_nodrop", 0, DW'(drop_cnt[0]), '0);
        tx_tready[0] = 1;
        for (int i = 0; i < 17; i++) step();

        // 4: GEN with external loopback and an injected sequence jump
        mode[0] = 2'd2;
        step();
        for (int k = 0; k < 40; k++) begin
            chk("t4_seq", 0, DW'(tx_tdata[0][31:0]), DW'(k));
            chk("t4_last", 0, DW'(tx_tlast[0]), DW'((k % 4) == 3));
            if (k < 20)      rx0(1, tx_tdata[0], tx_tlast[0]);
            else if (k < 23) rx0(1, DW'(100 + k - 20), 0);
            else             rx0(0, '0, 0);
            step();
        end
        chk("t4_err", 0, DW'(err_cnt[0]), DW'(1));

        // 5: GEN->LOOP at frame end, then LOOP->GEN deferred to tlast acceptance
        mode[0] = 2'd1;
        step(); step(); step();
        chk("t5_seq43", 0, DW'(tx_tdata[0][31:0]), DW'(43));
        step();
        chk("t5_loop_empty", 0, DW'(tx_tvalid[0]), '0);
        tx_tready[0] = 0;
        rx0(1, DW'(300), 0);
        step();
        mode[0] = 2'd2;
        for (int i = 1; i < 6; i++) begin
            rx0(1, DW'(300 + i), i == 5);
            step();
        end
        rx0(0, '0, 0);
        step();
        chk("t5_still_loop", 0, DW'(tx_tdata[0][31:0]), DW'(300));
        tx_tready[0] = 1;
        for (int i = 0; i < 6; i++) begin
            chk("t5_drain", 0, DW'(tx_tdata[0][31:0]), DW'(300 + i));
            step();
        end
        chk("t5_gen0", 0, tx_tdata[0], '0);
        chk("t5_gen_vld", 0, DW'(tx_tvalid[0]), DW'(1));

        // 6: link drop mid-frame, clear racing an error, reset
        mode[0] = 2'd1;
        step(); step(); step(); step();
        chk("t6_loop", 0, DW'(tx_tvalid[0]), '0);
        tx_tready[0] = 0;
        for (int i = 0; i < 3; i++) begin
            rx0(1, DW'(600 + i), 0);
            step();
        end
        rx0(0, '0, 0);
        chk("t6_pending", 0, DW'(tx_tvalid[0]), DW'(1));
        channel_up[0] = 0;
        step();
        chk("t6_down_vld", 0, DW'(tx_tvalid[0]), '0);
        channel_up[0] = 1;
        step();
        chk("t6_flushed", 0, DW'(tx_tvalid[0]), '0);
        chk("t6_err_hold", 0, DW'(err_cnt[0]), DW'(1));
        mode[0] = 2'd2;
        step();
        rx0(1, DW'(5), 0);
        step();
        rx0(1, DW'(9), 0);
        clr_stat[0] = 1;
        step();
        clr_stat[0] = 0;
        chk("t6_clr_err", 0, DW'(err_cnt[0]), '0);
        rx0(1, DW'(10), 0);
        step();
        rx0(0, '0, 0);
        chk("t6_clean", 0, DW'(err_cnt[0]), '0);
        step();

        rst_n = 0;
        step();
        for (int c = 0; c < CH; c++) begin
            chk("rst2_tvalid", c, DW'(tx_tvalid[c]), '0);
            chk("rst2_tdata", c, tx_tdata[c], '0);
            chk("rst2_tkeep", c, DW'(tx_tkeep[c]), '0);
            chk("rst2_tlast", c, DW'(tx_tlast[c]), '0);
            chk("rst2_ovf", c, DW'(overflow[c]), '0);
            chk("rst2_drop", c, DW'(drop_cnt[c]), '0);
            chk("rst2_err", c, DW'(err_cnt[c]), '0);
        end
        rst_n = 1;
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
